icache_fill_server: RTL and testbench
=====================================

Name: icache_fill_server

Overview:
- L2-side responder for the instruction cache refill interface. It accepts a single-line fill request from the icache (valid/address) and fetches the full BLOCK_WIDTH line from a narrower memory port as MEM_WIDTH beats.
- It assembles the line and returns it with a one-cycle ready pulse.
- A one-line fill buffer holds the most recent line, so an immediately repeated request for that line is served without memory traffic.

Parameters:
- ADDRESS_BITS, 32, request/memory address width
- BLOCK_WIDTH, 256, cache line width in bits; must equal the icache BLOCK_WIDTH
- MEM_WIDTH, 64, memory data beat width; BLOCK_WIDTH must be an integer multiple of it
- (derived) BEATS = BLOCK_WIDTH/MEM_WIDTH; LINE_OFF = log2(BLOCK_WIDTH/8); BEAT_BYTES = MEM_WIDTH/8

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  icache fill request
- address_in  in  ADDRESS_BITS  icache request address, any byte within the line
- ready_o  out  1  one-cycle pulse; data_out is valid in that cycle
- data_out  out  BLOCK_WIDTH  assembled line; beat k at [k*MEM_WIDTH +: MEM_WIDTH]
- invalidate  in  1  clears the fill buffer's valid bit
- busy  out  1  high whenever state != IDLE
- mem_req_valid  out  1  memory beat read request
- mem_req_ready  in  1  memory accepts request
- mem_req_address  out  ADDRESS_BITS  byte address of the beat
- mem_resp_valid  in  1  in-order beat response, no backpressure
- mem_resp_data  in  MEM_WIDTH  beat data

Behaviour:
- Clock, reset and clocking: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: ready_o=0, busy=0, mem_req_valid=0, data_out=0, buffer valid=0, base=0, counters=0, state=IDLE.
- States: IDLE, FETCH, RESP.
- ready_o = (state==RESP). data_out is driven from the line register and is stable outside FETCH.
- IDLE, valid_i=1, buffer hit (valid && buf_tag == address_in[ADDRESS_BITS-1:LINE_OFF] && !invalidate): go to RESP. ready_o is high the cycle after valid_i.
- IDLE, valid_i=1, otherwise: base = address_in with low LINE_OFF bits zeroed; req_cnt=0; rsp_cnt=0; go to FETCH.
- FETCH, request side:
  - mem_req_valid = (req_cnt < BEATS); mem_req_address = base + req_cnt*BEAT_BYTES.
  - req_cnt increments on mem_req_valid && mem_req_ready.
  - Address and valid hold stable under backpressure.
- FETCH, response side:
  - On mem_resp_valid, write mem_resp_data to beat rsp_cnt of the line register; rsp_cnt increments.
  - On the beat with rsp_cnt==BEATS-1: set buf_tag = base tag, buffer valid=1, go to RESP.
  - ready_o pulses the cycle after the last response beat.
- RESP: held exactly one cycle, then IDLE. A new valid_i can be accepted in the following IDLE cycle.
- valid_i outside IDLE is ignored (the icache blocks while waiting).
- mem_resp_valid outside FETCH is ignored. Responses beyond BEATS in FETCH cannot occur, since responses never exceed issued requests.
- Counters are log2(BEATS)+1 bits wide. Address arithmetic is modulo 2^ADDRESS_BITS (wraps at the top of memory).
- invalidate: buffer valid clears at the next edge.
  - Coincident with fill completion: invalidate wins, the buffer stays invalid, but the RESP pulse and data are still delivered.
  - Coincident with an IDLE lookup: the lookup misses.
- Reset mid-operation: all state returns to reset values immediately. The memory side is reset by the same rst_n, and late responses arriving in IDLE are discarded.
- Minimum miss latency: BEATS+1 cycles from valid_i to ready_o, assuming zero-latency memory.

Test Plan (BLOCK_WIDTH=256, MEM_WIDTH=64, ADDRESS_BITS=32):
1. Reset: assert rst_n=0 mid-cycle -> ready_o=0, busy=0, mem_req_valid=0, data_out=0 asynchronously.
2. Miss fill: valid_i with address_in=0x0000_1234 -> mem_req_address 0x1220, 0x1228, 0x1230, 0x1238 in order; responses 0xA0, 0xA1, 0xA2, 0xA3 -> data_out={0xA3,0xA2,0xA1,0xA0} (zero-extended beats), ready_o high exactly one cycle, the cycle after 0xA3.
3. Backpressure: repeat 2 with mem_req_ready=0 for 3 cycles on beat 1 -> mem_req_address holds 0x1228 and mem_req_valid stays high; no beat is skipped or duplicated; exactly 4 handshakes.
4. Buffer hit: after 2, valid_i with 0x0000_123C -> no mem_req_valid; ready_o the next cycle with the same line.
5. Invalidate: pulse invalidate, then valid_i with 0x1220 -> full 4-beat refetch. Invalidate coincident with the last beat of a fill -> RESP still occurs, and the following same-line request refetches.
6. Reset mid-fill: reset after 2 responses -> idle state; next request 0x2000 issues beat 0 at 0x2000; stray responses injected during IDLE do not alter data_out.

Source files
------------

// File: rtl/icache_fill_server_if.sv
// rtl/icache_fill_server_if.sv - icache refill request and memory beat port bundle
interface icache_fill_server_if #(
  parameter int ADDRESS_BITS = 32,
  parameter int BLOCK_WIDTH  = 256,
  parameter int MEM_WIDTH    = 64
);
  logic                    valid_i;
  logic [ADDRESS_BITS-1:0] address_in;
  logic                    ready_o;
  logic [BLOCK_WIDTH-1:0]  data_out;
  logic                    invalidate;
  logic                    busy;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDRESS_BITS-1:0] mem_req_address;
  logic                    mem_resp_valid;
  logic [MEM_WIDTH-1:0]    mem_resp_data;

  modport master (
    output valid_i, address_in, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ready_o, data_out, busy, mem_req_valid, mem_req_address
  );

  modport slave (
    input  valid_i, address_in, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    output ready_o, data_out, busy, mem_req_valid, mem_req_address
  );
endinterface

// File: rtl/icache_fill_server.sv
// rtl/icache_fill_server.sv - fetches an icache line as memory beats, with a one-line fill buffer
module icache_fill_server #(
  parameter int ADDRESS_BITS = 32,
  parameter int BLOCK_WIDTH  = 256,
  parameter int MEM_WIDTH    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_fill_server_if.slave  bus
);
  localparam int BEATS      = BLOCK_WIDTH / MEM_WIDTH;
  localparam int LINE_OFF   = $clog2(BLOCK_WIDTH / 8);
  localparam int BEAT_BYTES = MEM_WIDTH / 8;
  localparam int CW         = $clog2(BEATS) + 1;
  localparam int TAG_W      = ADDRESS_BITS - LINE_OFF;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                  r_state;
  logic [BLOCK_WIDTH-1:0]  r_line;
  logic                    r_buf_valid;
  logic [TAG_W-1:0]        r_buf_tag;
  logic [ADDRESS_BITS-1:0] r_base;
  logic [CW-1:0]           r_req_cnt;
  logic [CW-1:0]           r_rsp_cnt;

  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_req_valid;

  assign w_tag       = bus.address_in[ADDRESS_BITS-1:LINE_OFF];
  // A coincident invalidate must turn a would-be hit into a refetch.
  assign w_hit       = r_buf_valid && (r_buf_tag == w_tag) && !bus.invalidate;
  assign w_req_valid = (r_state == FETCH) && (r_req_cnt < CW'(BEATS));

  assign bus.ready_o         = (r_state == RESP);
  assign bus.busy            = (r_state != IDLE);
  assign bus.data_out        = r_line;
  assign bus.mem_req_valid   = w_req_valid;
  assign bus.mem_req_address = r_base + (ADDRESS_BITS'(r_req_cnt) * ADDRESS_BITS'(BEAT_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_line      <= '0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_base      <= '0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.valid_i) begin
            if (w_hit) begin
              r_state <= RESP;
            end else begin
              r_base    <= {w_tag, {LINE_OFF{1'b0}}};
              r_req_cnt <= '0;
              r_rsp_cnt <= '0;
              r_state   <= FETCH;
            end
          end
        end
        FETCH: begin
          if (w_req_valid && bus.mem_req_ready) begin
            r_req_cnt <= r_req_cnt + CW'(1);
          end
          if (bus.mem_resp_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_rsp_cnt == CW'(k)) begin
                r_line[k*MEM_WIDTH +: MEM_WIDTH] <= bus.mem_resp_data;
              end
            end
            r_rsp_cnt <= r_rsp_cnt + CW'(1);
            if (r_rsp_cnt == CW'(BEATS - 1)) begin
              r_buf_tag   <= r_base[ADDRESS_BITS-1:LINE_OFF];
              r_buf_valid <= 1'b1;
              r_state     <= RESP;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Placed last so it overrides a fill completing in the same cycle.
      if (bus.invalidate) begin
        r_buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_fill_server.sv
// tb/tb_icache_fill_server.sv - randomized bench for icache_fill_server against a transaction-level model
module tb_icache_fill_server;
  localparam int AW    = 32;
  localparam int BW    = 256;
  localparam int MW    = 64;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fill_server_if #(.ADDRESS_BITS(AW), .BLOCK_WIDTH(BW), .MEM_WIDTH(MW)) bus ();

  icache_fill_server #(.ADDRESS_BITS(AW), .BLOCK_WIDTH(BW), .MEM_WIDTH(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    bit          inv_req;
    bit          inv_last;
    int          bp;
    logic [31:0] salt;
  } cmd_t;

  cmd_t        cq[$];
  cmd_t        cur;
  bit          dir_mode = 1'b1;
  bit          m_valid;
  logic [26:0] m_tag;
  logic [255:0] m_line;
  bit          t_active, t_hit;
  logic [31:0] t_base;
  int          t_req, t_rsp, t_lat;
  logic [255:0] t_line;
  logic [255:0] last_line;
  logic [255:0] last_data;
  logic [255:0] exp_line;
  int          last_lat;
  int          done_cnt = 0;
  int          bp_left;
  logic [31:0] pend[$];
  logic [31:0] hs_log[$];
  bit          p_accept, p_inv, p_hs, p_resp;
  logic [31:0] p_addr;
  bit          exp_ready, exp_mreq, vv, iv, rv, mr, hs;
  logic [31:0] va, ra;
  logic [63:0] rdat;

  function automatic logic [63:0] mem_fn(input logic [31:0] a, input logic [31:0] s, input bit dm);
    if (dm) return 64'hA0 + 64'((a >> 3) & 32'd3);
    return {a ^ s, ~a ^ {s[15:0], s[31:16]}};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", bus.ready_o, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mreq", bus.mem_req_valid, 1'b0);
      chk("rst_data", bus.data_out, '0);
      m_valid = 0; t_active = 0; last_line = '0; bp_left = 0;
      pend.delete();
      p_accept = 0; p_inv = 0; p_hs = 0; p_resp = 0; p_addr = '0;
      bus.valid_i = 0; bus.address_in = '0; bus.invalidate = 0;
      bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
    end else begin
      exp_ready = 0;
      if (p_accept) begin
        t_active = 1; t_lat = 1;
        hs_log.delete();
        t_hit = m_valid && (m_tag == p_addr[31:5]) && !p_inv;
        if (t_hit) begin
          exp_ready = 1;
        end else begin
          t_base = {p_addr[31:5], 5'b0};
          t_req = 0; t_rsp = 0;
          for (int k = 0; k < BEATS; k++) t_line[k*64 +: 64] = mem_fn(t_base + 32'(k * 8), cur.salt, dir_mode);
        end
      end else if (t_active) begin
        t_lat++;
        if (!t_hit) begin
          if (p_hs) t_req++;
          if (p_resp) t_rsp++;
          if (t_rsp == BEATS) exp_ready = 1;
        end
      end
      exp_mreq = t_active && !t_hit && !exp_ready && (t_req < BEATS);
      chk("ready_o", bus.ready_o, exp_ready);
      chk("busy", bus.busy, t_active);
      chk("mem_req_valid", bus.mem_req_valid, exp_mreq);
      if (exp_mreq) chk("mem_req_address", bus.mem_req_address, t_base + 32'(t_req * 8));
      if (exp_ready) begin
        exp_line = t_hit ? m_line : t_line;
        chk("data_out_resp", bus.data_out, exp_line);
        last_line = exp_line;
        if (!t_hit) begin
          m_valid = 1; m_tag = t_base[31:5]; m_line = t_line;
        end
      end else if (!(t_active && !t_hit)) begin
        chk("data_out_stable", bus.data_out, last_line);
      end
      if (p_inv) m_valid = 0;

      vv = 0; va = $urandom; iv = 0; rv = 0; rdat = '0;
      mr = dir_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (exp_mreq && t_req == 1 && bp_left > 0) begin
        mr = 0; bp_left--;
      end
      hs = bus.mem_req_valid && mr;
      if (hs) begin
        pend.push_back(bus.mem_req_address);
        hs_log.push_back(bus.mem_req_address);
      end
      if (pend.size() > 0 && (dir_mode || $urandom_range(0, 2) != 0)) begin
        ra = pend.pop_front();
        rv = 1;
        rdat = mem_fn(ra, cur.salt, dir_mode);
        if (cur.inv_last && t_rsp == BEATS - 1) iv = 1;
      end
      p_accept = 0;
      if (t_active) begin
        if (!dir_mode && $urandom_range(0, 3) == 0) vv = 1;
        if (exp_ready) begin
          last_lat = t_lat; last_data = bus.data_out;
          t_active = 0; done_cnt++;
        end
      end else if (cq.size() > 0) begin
        cur = cq.pop_front();
        case (cur.kind)
          0: begin
            vv = 1; va = cur.addr; iv = cur.inv_req; bp_left = cur.bp; p_accept = 1;
          end
          1: begin
            iv = 1; done_cnt++;
          end
          default: begin
            rv = 1; rdat = {$urandom, $urandom}; done_cnt++;
          end
        endcase
      end
      bus.valid_i = vv; bus.address_in = va; bus.invalidate = iv;
      bus.mem_req_ready = mr; bus.mem_resp_valid = rv; bus.mem_resp_data = rdat;
      p_hs = hs; p_resp = rv; p_inv = iv; p_addr = va;
    end
  end

  function automatic cmd_t mk(input int kind, input logic [31:0] addr, input bit inv_req,
                              input bit inv_last, input int bp, input logic [31:0] salt);
    cmd_t c;
    c.kind = kind; c.addr = addr; c.inv_req = inv_req; c.inv_last = inv_last; c.bp = bp; c.salt = salt;
    return c;
  endfunction

  task automatic run(input cmd_t c);
    int s;
    s = done_cnt;
    cq.push_back(c);
    for (int i = 0; i < 400 && done_cnt == s; i++) @(posedge clk);
    checks++;
    if (done_cnt == s) begin
      errors++;
      $display("FAIL timeout: command kind %0d addr %0h got no completion, required one", c.kind, c.addr);
    end
  endtask

  task automatic chk_addrs(input string name, input logic [31:0] base);
    chk({name, "_hs_count"}, 256'(hs_log.size()), 256'(BEATS));
    for (int k = 0; k < BEATS && k < hs_log.size(); k++) chk({name, "_hs_addr"}, hs_log[k], base + 32'(k * 8));
  endtask

  localparam logic [255:0] LINE_A =
    256'h00000000000000a3_00000000000000a2_00000000000000a1_00000000000000a0;
  logic [31:0] lines [4] = '{32'h0000_1220, 32'h0000_8000, 32'hFFFF_FFC0, 32'h1234_5660};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_ready", bus.ready_o, 1'b0);
    chk("init_data", bus.data_out, '0);
    #1 rst_n = 1'b1;

    dir_mode = 1;
    run(mk(0, 32'h0000_1234, 0, 0, 0, 0));
    chk_addrs("miss", 32'h0000_1220);
    chk("miss_data", last_data, LINE_A);
    chk("miss_latency", last_lat, 5);

    run(mk(1, 0, 0, 0, 0, 0));
    run(mk(0, 32'h0000_1234, 0, 0, 3, 0));
    chk_addrs("bp", 32'h0000_1220);
    chk("bp_data", last_data, LINE_A);
    chk("bp_latency", last_lat, 8);

    run(mk(0, 32'h0000_123C, 0, 0, 0, 0));
    chk("hit_hs_count", hs_log.size(), 0);
    chk("hit_latency", last_lat, 1);
    chk("hit_data", last_data, LINE_A);

    run(mk(1, 0, 0, 0, 0, 0));
    run(mk(0, 32'h0000_1220, 0, 0, 0, 0));
    chk_addrs("inv_refetch", 32'h0000_1220);
    run(mk(0, 32'h0000_1220, 0, 0, 0, 0));
    chk("inv_then_hit", hs_log.size(), 0);
    run(mk(1, 0, 0, 0, 0, 0));
    run(mk(0, 32'h0000_1220, 0, 1, 0, 0));
    chk("inv_last_latency", last_lat, 5);
    run(mk(0, 32'h0000_1220, 0, 0, 0, 0));
    chk_addrs("after_inv_last", 32'h0000_1220);
    run(mk(0, 32'h0000_1220, 1, 0, 0, 0));
    chk_addrs("inv_with_lookup", 32'h0000_1220);

    cq.push_back(mk(0, 32'h0000_5000, 0, 0, 0, 0));
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (t_active && t_rsp >= 2) break;
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", bus.ready_o, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_mreq", bus.mem_req_valid, 1'b0);
    chk("async_rst_data", bus.data_out, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run(mk(2, 0, 0, 0, 0, 0));
    run(mk(2, 0, 0, 0, 0, 0));
    #1;
    chk("stray_data", bus.data_out, '0);
    run(mk(0, 32'h0000_2000, 0, 0, 0, 0));
    chk_addrs("post_reset", 32'h0000_2000);
    run(mk(0, 32'h0000_1220, 0, 0, 0, 0));
    chk_addrs("post_reset_buf", 32'h0000_1220);

    dir_mode = 0;
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)
        run(mk(0, lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom));
      else if (r == 7)
        run(mk(1, 0, 0, 0, 0, 0));
      else if (r == 8)
        run(mk(2, 0, 0, 0, 0, 0));
      else
        run(mk(0, 32'hFFFF_FFE0 | 32'($urandom_range(0, 31)), 0, 0, 0, $urandom));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
